// File: rtl/lcd_char_writer.sv
// rtl/lcd_char_writer.sv - 32-char frame capture and HD44780 4-bit refresh engine
module lcd_char_writer #(
  parameter logic [31:0] INIT_WAIT = 32'd2_000_000,
  parameter logic [15:0] E_CYCLES  = 16'd25,
  parameter logic [31:0] CMD_WAIT  = 32'd5_000,
  parameter logic [31:0] CLR_WAIT  = 32'd200_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] char_i,
  input  logic       valid_i,
  output logic       busy_o,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_db
);

  typedef enum logic [2:0] {PWR, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2} state_t;
  typedef enum logic [2:0] {PH_LOAD, PH_SETUP, PH_EHI, PH_ELO, PH_WAIT} phase_t;

  state_t      state;
  phase_t      phase;
  logic [31:0] cnt;
  logic [3:0]  step;
  logic [7:0]  cur_byte;
  logic        cur_is_byte;
  logic        low_nib;

  logic [7:0]  buffer [32];
  logic [4:0]  ptr;
  logic        pending;
  logic        take;

  logic [7:0]  item_byte;
  logic        item_rs;
  logic        item_is_byte;
  logic        long_wait;
  logic [31:0] wait_lim;
  logic        e_done;
  logic        w_done;

  assign lcd_rw    = 1'b0;
  assign take      = (state == IDLE) && pending;
  // The 0x01 clear and the very first init nibble need the long settle time
  assign long_wait = ((state == INIT) && (step == 4'd0)) ||
                     (cur_is_byte && !lcd_rs && (cur_byte == 8'h01));
  assign wait_lim  = long_wait ? CLR_WAIT : CMD_WAIT;
  assign e_done    = (cnt + 32'd1) >= {16'd0, E_CYCLES};
  assign w_done    = (cnt + 32'd1) >= wait_lim;

  // Frame capture: bursts always start at address 0; only a full 32-char burst arms a refresh
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr     <= 5'd0;
      pending <= 1'b0;
      for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
    end else begin
      if (valid_i) begin
        buffer[ptr] <= char_i;
        ptr         <= ptr + 5'd1;
      end else begin
        ptr <= 5'd0;
      end
      if (valid_i && (ptr == 5'd31)) pending <= 1'b1;
      else if (take)                 pending <= 1'b0;
    end
  end

  // Select the nibble/byte the current state and step want to put on the bus
  always_comb begin
    item_byte    = 8'h00;
    item_rs      = 1'b0;
    item_is_byte = 1'b1;
    case (state)
      INIT: begin
        case (step)
          4'd0, 4'd1, 4'd2: begin item_byte = 8'h30; item_is_byte = 1'b0; end
          4'd3:             begin item_byte = 8'h20; item_is_byte = 1'b0; end
          4'd4:             item_byte = 8'h28;
          4'd5:             item_byte = 8'h0C;
          4'd6:             item_byte = 8'h06;
          default:          item_byte = 8'h01;
        endcase
      end
      ADDR1: item_byte = 8'h80;
      ADDR2: item_byte = 8'hC0;
      LINE1, LINE2: begin
        item_byte = buffer[{state == LINE2, step}];
        item_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  // Main sequencer: power-on wait, init, idle, and the two-line refresh, each item run through load/setup/e-high/e-low/wait
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= PWR;
      phase       <= PH_LOAD;
      cnt         <= 32'd0;
      step        <= 4'd0;
      cur_byte    <= 8'h00;
      cur_is_byte <= 1'b0;
      low_nib     <= 1'b0;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_db      <= 4'h0;
      busy_o      <= 1'b1;
    end else begin
      case (state)
        PWR: begin
          if ((cnt + 32'd1) >= INIT_WAIT) begin
            state <= INIT;
            step  <= 4'd0;
            cnt   <= 32'd0;
            phase <= PH_LOAD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        IDLE: begin
          if (pending) begin
            state  <= ADDR1;
            step   <= 4'd0;
            cnt    <= 32'd0;
            phase  <= PH_LOAD;
            busy_o <= 1'b1;
          end
        end
        default: begin
          case (phase)
            PH_LOAD: begin
              cur_byte    <= item_byte;
              cur_is_byte <= item_is_byte;
              low_nib     <= 1'b0;
              lcd_rs      <= item_rs;
              lcd_db      <= item_byte[7:4];
              phase       <= PH_SETUP;
            end
            PH_SETUP: begin
              lcd_e <= 1'b1;
              cnt   <= 32'd0;
              phase <= PH_EHI;
            end
            PH_EHI: begin
              if (e_done) begin
                lcd_e <= 1'b0;
                cnt   <= 32'd0;
                phase <= PH_ELO;
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
            PH_ELO: begin
              if (e_done) begin
                cnt <= 32'd0;
                if (cur_is_byte && !low_nib) begin
                  low_nib <= 1'b1;
                  lcd_db  <= cur_byte[3:0];
                  phase   <= PH_SETUP;
                end else begin
                  phase <= PH_WAIT;
                end
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
            PH_WAIT: begin
              if (w_done) begin
                cnt   <= 32'd0;
                phase <= PH_LOAD;
                case (state)
                  INIT: begin
                    if (step == 4'd7) begin state <= IDLE; busy_o <= 1'b0; end
                    step <= step + 4'd1;
                  end
                  ADDR1: begin state <= LINE1; step <= 4'd0; end
                  LINE1: begin
                    if (step == 4'd15) state <= ADDR2;
                    step <= step + 4'd1;
                  end
                  ADDR2: begin state <= LINE2; step <= 4'd0; end
                  default: begin
                    if (step == 4'd15) begin state <= IDLE; busy_o <= 1'b0; end
                    step <= step + 4'd1;
                  end
                endcase
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
            default: phase <= PH_LOAD;
          endcase
        end
      endcase
    end
  end

endmodule
